// File: rtl/ram_responder.sv
// Single-port 256x32 RAM at the memory end of the shared RAM bus.
// Zero-fills the array after every reset, then serves one read or write per cycle.
//
// state | meaning
// CLEAR | sweeping zeros into the array, bus ignored, BUSY high
// READY | servicing bus requests with 1-cycle registered ACK/data
module ram_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iRAM_CE,
    input  logic              iRAM_RD,
    input  logic              iRAM_WR,
    input  logic [ADDR_W-1:0] iRAM_ADDR,
    input  logic [DATA_W-1:0] iRAM_DATA_WR,
    output logic [DATA_W-1:0] oRAM_DATA_RD,
    output logic              oRAM_ACK,
    output logic              oRAM_BUSY,
    output logic              oRAM_ERR
);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    logic [ADDR_W:0]   clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              req_rd;
    logic              req_wr;
    logic              req_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        req_rd    = iRAM_CE & iRAM_RD & ~iRAM_WR;
        req_wr    = iRAM_CE & iRAM_WR & ~iRAM_RD;
        req_err   = iRAM_CE & iRAM_RD & iRAM_WR;
        mem_we    = 1'b0;
        mem_addr  = iRAM_ADDR;
        mem_wdata = iRAM_DATA_WR;
        if (state == CLEAR) begin
            mem_we    = iRST_N;
            mem_addr  = clr_cnt[ADDR_W-1:0];
            mem_wdata = '0;
        end else if (req_wr) begin
            mem_we = iRST_N;
        end
    end

    // Array has no reset path; it is zeroed by the sweep instead.
    always_ff @(posedge iCLK) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state        <= CLEAR;
            clr_cnt      <= '0;
            oRAM_DATA_RD <= '0;
            oRAM_ACK     <= 1'b0;
            oRAM_ERR     <= 1'b0;
            oRAM_BUSY    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    oRAM_ACK <= 1'b0;
                    oRAM_ERR <= 1'b0;
                    clr_cnt  <= clr_cnt + 1'b1;
                    if (clr_cnt[ADDR_W-1:0] == ADDR_W'(DEPTH-1)) begin
                        state     <= READY;
                        oRAM_BUSY <= 1'b0;
                    end
                end
                READY: begin
                    oRAM_ACK <= req_rd | req_wr | req_err;
                    oRAM_ERR <= req_err;
                    if (req_rd) begin
                        oRAM_DATA_RD <= mem[iRAM_ADDR];
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: reset sweep, read/write, error, CE gating,
// and reset asserted in the middle of a cycle.
module tb_ram_responder;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iRAM_CE = 1'b0;
    logic        iRAM_RD = 1'b0;
    logic        iRAM_WR = 1'b0;
    logic [7:0]  iRAM_ADDR = '0;
    logic [31:0] iRAM_DATA_WR = '0;
    logic [31:0] oRAM_DATA_RD;
    logic        oRAM_ACK;
    logic        oRAM_BUSY;
    logic        oRAM_ERR;

    int n_checks = 0;
    int n_pass   = 0;

    ram_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(256)) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iRAM_CE     (iRAM_CE),
        .iRAM_RD     (iRAM_RD),
        .iRAM_WR     (iRAM_WR),
        .iRAM_ADDR   (iRAM_ADDR),
        .iRAM_DATA_WR(iRAM_DATA_WR),
        .oRAM_DATA_RD(oRAM_DATA_RD),
        .oRAM_ACK    (oRAM_ACK),
        .oRAM_BUSY   (oRAM_BUSY),
        .oRAM_ERR    (oRAM_ERR)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Inputs change at a negedge; outputs are sampled at the following negedge.
    task automatic step(input logic ce, input logic rd, input logic wr,
                        input logic [7:0] addr, input logic [31:0] data);
        iRAM_CE = ce; iRAM_RD = rd; iRAM_WR = wr;
        iRAM_ADDR = addr; iRAM_DATA_WR = data;
        @(negedge iCLK);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    // Runs the 256-edge sweep; optionally injects a write at edge 5.
    task automatic sweep(input string tag, input bit poke);
        int bad_busy = 0;
        int bad_resp = 0;
        for (int i = 1; i <= 256; i++) begin
            if (poke && i == 5) step(1'b1, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
            else idle();
            if (i < 256 && oRAM_BUSY !== 1'b1) bad_busy++;
            if (oRAM_ACK !== 1'b0 || oRAM_ERR !== 1'b0) bad_resp++;
        end
        check({tag, "_busy_during"}, 32'(bad_busy), 32'd0);
        check({tag, "_no_resp"}, 32'(bad_resp), 32'd0);
        check({tag, "_busy_fall"}, {31'd0, oRAM_BUSY}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge iCLK);
        check("rst_busy", {31'd0, oRAM_BUSY}, 32'd1);
        check("rst_ack", {31'd0, oRAM_ACK}, 32'd0);
        check("rst_data", oRAM_DATA_RD, 32'h0);
        iRST_N = 1'b1;

        sweep("sweep1", 1'b1);

        step(1'b1, 1'b1, 1'b0, 8'h00, 32'h0);
        check("rd00_ack", {31'd0, oRAM_ACK}, 32'd1);
        check("rd00_data", oRAM_DATA_RD, 32'h0);
        step(1'b1, 1'b1, 1'b0, 8'h7F, 32'h0);
        check("rd7f_data", oRAM_DATA_RD, 32'h0);
        step(1'b1, 1'b1, 1'b0, 8'hFF, 32'h0);
        check("rdff_data", oRAM_DATA_RD, 32'h0);

        step(1'b1, 1'b0, 1'b1, 8'h42, 32'hCAFEF00D);
        check("wr42_ack", {31'd0, oRAM_ACK}, 32'd1);
        check("wr42_data_hold", oRAM_DATA_RD, 32'h0);
        step(1'b1, 1'b1, 1'b0, 8'h42, 32'h0);
        check("rd42_ack", {31'd0, oRAM_ACK}, 32'd1);
        check("rd42_data", oRAM_DATA_RD, 32'hCAFEF00D);
        idle();
        check("idle_ack", {31'd0, oRAM_ACK}, 32'd0);
        repeat (9) idle();
        check("idle_hold", oRAM_DATA_RD, 32'hCAFEF00D);

        step(1'b1, 1'b1, 1'b1, 8'h42, 32'h11111111);
        check("err_ack", {31'd0, oRAM_ACK}, 32'd1);
        check("err_err", {31'd0, oRAM_ERR}, 32'd1);
        check("err_data_hold", oRAM_DATA_RD, 32'hCAFEF00D);
        idle();
        check("err_pulse", {31'd0, oRAM_ERR}, 32'd0);

        step(1'b1, 1'b1, 1'b0, 8'h10, 32'h0);
        check("rd10_after_clear_wr", oRAM_DATA_RD, 32'h0);
        step(1'b1, 1'b1, 1'b0, 8'h42, 32'h0);
        check("rd42_after_err", oRAM_DATA_RD, 32'hCAFEF00D);

        step(1'b0, 1'b0, 1'b1, 8'h05, 32'h12345678);
        check("ce0_ack", {31'd0, oRAM_ACK}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 8'h05, 32'h0);
        check("rd05", oRAM_DATA_RD, 32'h0);

        step(1'b1, 1'b0, 1'b1, 8'hFF, 32'hA5A5A5A5);
        step(1'b1, 1'b1, 1'b0, 8'hFF, 32'h0);
        check("rdff_pre_rst", oRAM_DATA_RD, 32'hA5A5A5A5);
        #2 iRST_N = 1'b0;
        #1;
        check("mid_rst_data", oRAM_DATA_RD, 32'h0);
        check("mid_rst_ack", {31'd0, oRAM_ACK}, 32'd0);
        check("mid_rst_busy", {31'd0, oRAM_BUSY}, 32'd1);
        idle();
        idle();
        iRST_N = 1'b1;

        sweep("sweep2", 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'hFF, 32'h0);
        check("rdff_post_rst_ack", {31'd0, oRAM_ACK}, 32'd1);
        check("rdff_post_rst", oRAM_DATA_RD, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
